// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_pkg : shared encodings and the register-match helper for hazard_ctrl |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    ST_RST_FLUSH = 2'd0,
    ST_RUN       = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } state_t;

  // x0 is hard-wired zero, so a write to it never produces a dependence.
  function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                     input logic [4:0] idx);
    return we && (rd != 5'd0) && (rd == idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_fwd_unit : EXE operand forward select for one source register       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] src_idx_i,
  input  logic [4:0] rd_idx_m_i,
  input  logic       reg_write_en_m_i,
  input  logic       load_m_i,
  input  logic [4:0] rd_idx_w_i,
  input  logic       reg_write_en_w_i,
  output logic [1:0] fwd_sel_o
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = reg_match(reg_write_en_m_i, rd_idx_m_i, src_idx_i) && !load_m_i;
  assign w_hit_w = reg_match(reg_write_en_w_i, rd_idx_w_i, src_idx_i);

  // A load in MEM has no data yet, so WB is the youngest usable producer.
  assign fwd_sel_o = w_hit_m ? FWD_MEM : (w_hit_w ? FWD_WB : FWD_REG);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl : pipeline stall/flush/forward sequencing for the 5-stage core |
// | Optional macro HAZARD_PERF_CNT_EN adds stall/flush performance counters.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned RESET_BUBBLES = 2,
  parameter int unsigned WAIT_CNT_W    = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] rs1_idx_d_i,
  input  logic [4:0] rs2_idx_d_i,
  input  logic       rs1_used_d_i,
  input  logic       rs2_used_d_i,
  input  logic       branch_d_i,
  input  logic       taken_d_i,
  input  logic [4:0] rs1_idx_e_i,
  input  logic [4:0] rs2_idx_e_i,
  input  logic [4:0] rd_idx_e_i,
  input  logic [4:0] rd_idx_m_i,
  input  logic [4:0] rd_idx_w_i,
  input  logic       reg_write_en_e_i,
  input  logic       reg_write_en_m_i,
  input  logic       reg_write_en_w_i,
  input  logic [1:0] result_src_e_i,
  input  logic [1:0] result_src_m_i,
  input  logic       dmem_req_m_i,
  input  logic       dmem_ready_m_i,
  output logic       enable_f_o,
  output logic       enable_d_o,
  output logic       flush_d_o,
  output logic       flush_e_o,
  output logic       rs1_depended_h_o,
  output logic [1:0] fwd_rs1_sel_e_o,
  output logic [1:0] fwd_rs2_sel_e_o,
  output logic       mem_timeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  state_t                  r_state,    w_state_nxt;
  logic [3:0]              r_bub_cnt,  w_bub_nxt;
  logic [WAIT_CNT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic                    r_timeout,  w_timeout_nxt;

  logic       w_load_e, w_load_m;
  logic       w_hit_e, w_hit_m;
  logic       w_mem_wait, w_load_use, w_br_dep, w_stall;
  logic       w_run_act, w_squash;
  logic [1:0] w_fwd1, w_fwd2;
  logic       w_in_rst;

  assign w_load_e = (result_src_e_i == RES_SRC_MEM);
  assign w_load_m = (result_src_m_i == RES_SRC_MEM);

  assign w_hit_e = (rs1_used_d_i && reg_match(reg_write_en_e_i, rd_idx_e_i, rs1_idx_d_i)) ||
                   (rs2_used_d_i && reg_match(reg_write_en_e_i, rd_idx_e_i, rs2_idx_d_i));
  assign w_hit_m = (rs1_used_d_i && reg_match(reg_write_en_m_i, rd_idx_m_i, rs1_idx_d_i)) ||
                   (rs2_used_d_i && reg_match(reg_write_en_m_i, rd_idx_m_i, rs2_idx_d_i));

  assign w_mem_wait = dmem_req_m_i && !dmem_ready_m_i;
  assign w_load_use = w_load_e && w_hit_e;
  assign w_br_dep   = branch_d_i && (w_hit_e || (w_load_m && w_hit_m));
  assign w_stall    = w_load_use || w_br_dep;
  assign w_in_rst   = (r_state == ST_RST_FLUSH);

  hazard_fwd_unit u_fwd_rs1 (
    .src_idx_i        (rs1_idx_e_i),
    .rd_idx_m_i       (rd_idx_m_i),
    .reg_write_en_m_i (reg_write_en_m_i),
    .load_m_i         (w_load_m),
    .rd_idx_w_i       (rd_idx_w_i),
    .reg_write_en_w_i (reg_write_en_w_i),
    .fwd_sel_o        (w_fwd1)
  );

  hazard_fwd_unit u_fwd_rs2 (
    .src_idx_i        (rs2_idx_e_i),
    .rd_idx_m_i       (rd_idx_m_i),
    .reg_write_en_m_i (reg_write_en_m_i),
    .load_m_i         (w_load_m),
    .rd_idx_w_i       (rd_idx_w_i),
    .reg_write_en_w_i (reg_write_en_w_i),
    .fwd_sel_o        (w_fwd2)
  );

  assign fwd_rs1_sel_e_o  = w_in_rst ? FWD_REG : w_fwd1;
  assign fwd_rs2_sel_e_o  = w_in_rst ? FWD_REG : w_fwd2;
  assign rs1_depended_h_o = !w_in_rst && rs1_used_d_i && !w_load_m &&
                            reg_match(reg_write_en_m_i, rd_idx_m_i, rs1_idx_d_i);
  assign mem_timeout_o    = r_timeout;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_RST_FLUSH;
      r_bub_cnt  <= 4'(RESET_BUBBLES);
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bub_cnt  <= w_bub_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bub_nxt     = r_bub_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_timeout_nxt = r_timeout;
    w_run_act     = 1'b0;
    w_squash      = 1'b0;
    enable_f_o    = 1'b0;
    enable_d_o    = 1'b0;
    flush_d_o     = 1'b0;
    flush_e_o     = 1'b0;
    case (r_state)
      ST_RST_FLUSH: begin
        flush_d_o = 1'b1;
        flush_e_o = 1'b1;
        if (r_bub_cnt <= 4'd1) w_state_nxt = ST_RUN;
        else                   w_bub_nxt   = r_bub_cnt - 4'd1;
      end
      ST_MEM_WAIT: begin
        if (dmem_ready_m_i) begin
          // Completing cycle behaves like RUN with the memory stall removed.
          w_run_act   = 1'b1;
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == {WAIT_CNT_W{1'b1}}) begin
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + 1'b1;
        end
      end
      default: begin
        if (w_mem_wait) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_run_act = 1'b1;
        end
      end
    endcase

    // A redirect is ignored during a stall since its operands may be stale.
    if (w_run_act) begin
      if (w_stall) begin
        flush_e_o = 1'b1;
      end else begin
        enable_f_o = 1'b1;
        enable_d_o = 1'b1;
        flush_d_o  = taken_d_i;
        w_squash   = taken_d_i;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!enable_d_o && !w_in_rst) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_squash)                 r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  logic w_unused_squash;
  assign w_unused_squash = w_squash;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hazard_ctrl : directed self-checking bench for hazard_ctrl              |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic       clk, resetn;
  logic [4:0] rs1_idx_d, rs2_idx_d, rs1_idx_e, rs2_idx_e, rd_idx_e, rd_idx_m, rd_idx_w;
  logic       rs1_used_d, rs2_used_d, branch_d, taken_d;
  logic       we_e, we_m, we_w, dmem_req, dmem_ready;
  logic [1:0] res_src_e, res_src_m;
  logic       enable_f, enable_d, flush_d, flush_e, rs1_dep, mem_timeout;
  logic [1:0] fwd1, fwd2;
  logic [3:0] ctl;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  hazard_ctrl #(.RESET_BUBBLES(2), .WAIT_CNT_W(2)) u_dut (
    .clk(clk), .resetn(resetn),
    .rs1_idx_d_i(rs1_idx_d), .rs2_idx_d_i(rs2_idx_d),
    .rs1_used_d_i(rs1_used_d), .rs2_used_d_i(rs2_used_d),
    .branch_d_i(branch_d), .taken_d_i(taken_d),
    .rs1_idx_e_i(rs1_idx_e), .rs2_idx_e_i(rs2_idx_e),
    .rd_idx_e_i(rd_idx_e), .rd_idx_m_i(rd_idx_m), .rd_idx_w_i(rd_idx_w),
    .reg_write_en_e_i(we_e), .reg_write_en_m_i(we_m), .reg_write_en_w_i(we_w),
    .result_src_e_i(res_src_e), .result_src_m_i(res_src_m),
    .dmem_req_m_i(dmem_req), .dmem_ready_m_i(dmem_ready),
    .enable_f_o(enable_f), .enable_d_o(enable_d),
    .flush_d_o(flush_d), .flush_e_o(flush_e),
    .rs1_depended_h_o(rs1_dep),
    .fwd_rs1_sel_e_o(fwd1), .fwd_rs2_sel_e_o(fwd2),
    .mem_timeout_o(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
`endif
  );

  // {enable_f, enable_d, flush_d, flush_e}
  assign ctl = {enable_f, enable_d, flush_d, flush_e};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    rs1_idx_d = 0; rs2_idx_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    branch_d = 0; taken_d = 0; rs1_idx_e = 0; rs2_idx_e = 0;
    rd_idx_e = 0; rd_idx_m = 0; rd_idx_w = 0; we_e = 0; we_m = 0; we_w = 0;
    res_src_e = 2'b00; res_src_m = 2'b00; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bubble_seq(input string tag);
    // Reset released mid-cycle: two flush cycles then RUN.
    check({tag, "_bub1"}, ctl, 4'b0011);
    step();
    check({tag, "_bub2"}, ctl, 4'b0011);
    step();
    check({tag, "_run"}, ctl, 4'b1100);
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    // A forwardable MEM write during reset must stay masked.
    rd_idx_m = 7; we_m = 1; rs2_idx_e = 7; rs1_idx_d = 7; rs1_used_d = 1;
    step(); step();
    check("rst_ctl", ctl, 4'b0011);
    check("rst_fwd2", fwd2, FWD_REG);
    check("rst_dep", rs1_dep, 0);
    check("rst_timeout", mem_timeout, 0);
    idle();
    #1 resetn = 1'b1;
    bubble_seq("init");

    // load-use: EXE load rd=5, ID rs1=5
    res_src_e = RES_SRC_MEM; rd_idx_e = 5; we_e = 1; rs1_idx_d = 5; rs1_used_d = 1;
    #1 check("load_use", ctl, 4'b0001);
    step(); idle();
    #1 check("load_use_after", ctl, 4'b1100);
    res_src_e = RES_SRC_MEM; rd_idx_e = 0; we_e = 1; rs1_idx_d = 0; rs1_used_d = 1;
    #1 check("load_use_x0", ctl, 4'b1100);
    idle();

    // forwarding priority and x0
    rd_idx_m = 7; we_m = 1; rd_idx_w = 7; we_w = 1; rs2_idx_e = 7;
    #1 check("fwd_mem_pri", fwd2, FWD_MEM);
    rd_idx_m = 0; rd_idx_w = 0;
    #1 check("fwd_x0", fwd2, FWD_REG);
    rd_idx_m = 7; rd_idx_w = 7; res_src_m = RES_SRC_MEM;
    #1 check("fwd_wb_mload", fwd2, FWD_WB);
    rs1_idx_e = 7; rd_idx_w = 3;
    #1 check("fwd1_none", fwd1, FWD_REG);
    res_src_m = 2'b00; rs1_idx_d = 7; rs1_used_d = 1;
    #1 check("rs1_dep", rs1_dep, 1);
    res_src_m = RES_SRC_MEM;
    #1 check("rs1_dep_load", rs1_dep, 0);
    check("mload_nobranch", ctl, 4'b1100);
    idle();

    // taken squash and branch dependence
    taken_d = 1;
    #1 check("taken", ctl, 4'b1110);
    branch_d = 1; rd_idx_e = 3; we_e = 1; rs1_idx_d = 3; rs1_used_d = 1;
    #1 check("taken_brdep", ctl, 4'b0001);
    idle();
    branch_d = 1; rd_idx_m = 4; we_m = 1; res_src_m = RES_SRC_MEM; rs2_idx_d = 4; rs2_used_d = 1;
    #1 check("brdep_mload", ctl, 4'b0001);
    idle();

    // memory wait: 3 cycles low, then ready
    dmem_req = 1;
    #1 check("mw_c1", ctl, 4'b0000);
    step(); check("mw_c2", ctl, 4'b0000);
    step(); check("mw_c3", ctl, 4'b0000);
    step(); dmem_ready = 1;
    #1 check("mw_done", ctl, 4'b1100);
    check("mw_no_to", mem_timeout, 0);
    step(); idle();
    #1 check("mw_run", ctl, 4'b1100);
    check("mw_no_to2", mem_timeout, 0);

    // 4 cycles low with 2-bit counter -> timeout, sticky
    dmem_req = 1;
    repeat (4) step();
    check("to_set", mem_timeout, 1);
    check("to_waiting", ctl, 4'b0000);
    step(); check("to_hold", mem_timeout, 1);
    dmem_ready = 1;
    #1 check("to_done", ctl, 4'b1100);
    step(); idle();
    #1 check("to_sticky", mem_timeout, 1);

    // reset while waiting
    dmem_req = 1;
    step();
    check("pre_rst_wait", ctl, 4'b0000);
    resetn = 1'b0;
    #1 check("rst_midwait", ctl, 4'b0011);
    check("rst_midwait_to", mem_timeout, 0);
    step(); idle();
    #1 resetn = 1'b1;
    bubble_seq("rerst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the five-stage MCU core.
- Sequences the pipeline: drives the per-stage enable/flush controls, EXE operand forwarding selects, and the ID-stage rs1 dependency/forward flag (`rs1_depended_h`).
- Freezes the whole pipeline while a data-memory access waits.
- Sits beside the stage instances inside the core top and replaces the constant enable / no-dependence ties.

Parameters:
- RESET_BUBBLES, 2, cycles after reset release during which fetch is held and ID/EXE are flushed (1..15).
- WAIT_CNT_W, 8, width of the memory-wait watchdog counter; timeout fires when the counter saturates.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- rs1_idx_d_i / rs2_idx_d_i  in  5  source indices of the instruction in ID
- rs1_used_d_i / rs2_used_d_i  in  1  ID instruction reads rs1 / rs2
- branch_d_i  in  1  ID instruction is a branch or jalr (resolved in ID)
- taken_d_i  in  1  ID redirect request
- rs1_idx_e_i / rs2_idx_e_i  in  5  source indices of the instruction in EXE
- rd_idx_e_i, rd_idx_m_i, rd_idx_w_i  in  5  destination index per stage
- reg_write_en_e_i, reg_write_en_m_i, reg_write_en_w_i  in  1  writes rd
- result_src_e_i, result_src_m_i  in  2  result source; RES_SRC_MEM marks a load
- dmem_req_m_i  in  1  MEM stage issues a data access
- dmem_ready_m_i  in  1  data memory completes this cycle
- enable_f_o  out  1  PC / IF advance
- enable_d_o  out  1  IF/ID register advance
- flush_d_o  out  1  load bubble into IF/ID
- flush_e_o  out  1  load bubble into ID/EXE
- rs1_depended_h_o  out  1  ID rs1 taken from MEM alu_result instead of regfile
- fwd_rs1_sel_e_o / fwd_rs2_sel_e_o  out  2  FWD_REG=00, FWD_MEM=01, FWD_WB=10
- mem_timeout_o  out  1  sticky: memory wait exceeded watchdog

Behaviour:
- **Match rule.** A stage write matches a source index only when its reg_write_en is 1, its rd != 0, and the indices are equal. x0 is never forwarded or stalled on.
- **Forwarding (combinational).**
  - fwd_*_sel_e_o = FWD_MEM if MEM matches and MEM is not a load.
  - Otherwise FWD_WB if WB matches.
  - Otherwise FWD_REG.
  - MEM has priority over WB.
- **rs1_depended_h_o** = rs1_used_d_i & MEM matches rs1_idx_d_i & MEM is not a load.
- **Stall causes**, priority high to low:
  1. mem_wait = dmem_req_m_i & ~dmem_ready_m_i.
  2. load_use = EXE is a load & EXE matches a used D source.
  3. br_dep = branch_d_i & (EXE matches a used D source, or MEM is a load that matches one).
- **States:** RST_FLUSH, RUN, MEM_WAIT. Registered state, a 4-bit bubble counter, and a WAIT_CNT_W wait counter.
- **Reset.** Asynchronous entry to RST_FLUSH with counter=RESET_BUBBLES and wait counter=0. While in reset: enable_f_o=0, enable_d_o=0, flush_d_o=1, flush_e_o=1, mem_timeout_o=0, fwd selects=00, rs1_depended_h_o=0.
- **RST_FLUSH.** Outputs as in reset. The counter decrements each cycle; at 1, go to RUN.
- **RUN.**
  - mem_wait: enables=0, flushes=0, go to MEM_WAIT with wait counter=1.
  - load_use or br_dep: enables=0, flush_e_o=1, flush_d_o=0. Re-evaluated every cycle, so there is no state change.
  - taken_d_i with no stall: enables=1, flush_d_o=1 (squashes the wrong-path fetch).
  - Otherwise: enables=1, flushes=0.
  - taken_d_i is ignored while a stall is active, because its operands may be stale.
- **MEM_WAIT.**
  - Outputs: enables=0, flushes=0. EXE/MEM/WB freeze through the same enables.
  - The wait counter increments each cycle and saturates at all-ones.
  - On saturation, mem_timeout_o sets and stays set until reset. The wait itself continues.
  - dmem_ready_m_i=1: the access completes this cycle. Outputs follow RUN rules for that cycle, with mem_wait evaluated as 0; then go to RUN and clear the wait counter.
- **Timing.** Latency from a hazard input to its control output is 0 cycles (same cycle).
- **Reset mid-wait:** immediate return to RST_FLUSH.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- **Defined:** adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle with enable_d_o=0 outside RST_FLUSH.
  - flush_cnt_o increments on each taken_d_i squash.
  - Both wrap modulo 2^32 and reset to 0.
- **Undefined:** neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package `hazard_pkg`:
  - FWD_REG / FWD_MEM / FWD_WB encodings
  - RES_SRC_MEM
  - state encodings
- Sub-module `hazard_fwd_unit`: the combinational match/forward logic for one operand, instantiated twice.
- FSM and counters stay in `hazard_ctrl`.

Test Plan:
- Reset release with RESET_BUBBLES=2 -> flush_d_o=flush_e_o=1 and enables=0 for exactly 2 cycles, then enables=1.
- EXE load rd=5, ID rs1=5 used -> one cycle enables=0, flush_e_o=1; next cycle enables=1.
- MEM ALU rd=7 and WB rd=7, EXE rs2=7 -> fwd_rs2_sel_e_o=01. Same with rd=0 -> 00.
- dmem_req=1, ready low for 3 cycles -> enables=0 for 3 cycles, then RUN the cycle ready=1. With WAIT_CNT_W=2 held for 4 cycles -> mem_timeout_o=1 and it stays set.
- taken_d_i=1 with no hazard -> flush_d_o=1, enables=1. taken_d_i=1 together with br_dep -> flush_d_o=0, stall.
- resetn low while in MEM_WAIT -> outputs immediately at reset values; RST_FLUSH sequence restarts.
